// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D), data first; 2 cycles per zero-wait access.
// Backpressure: stopCPU freezes the pipeline until every pending port is served for the current step.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stopCPU,
  output logic          err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

  state_t        r_state,     w_state;
  logic          r_mem_req,   w_mem_req;
  logic          r_mem_we,    w_mem_we;
  logic [AW-1:0] r_mem_addr,  w_mem_addr;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata;
  logic [DW-1:0] r_i_rdata,   w_i_rdata;
  logic [DW-1:0] r_d_rdata,   w_d_rdata;
  logic          r_err,       w_err;
  logic          r_i_done,    w_i_done;
  logic          r_d_done,    w_d_done;
  logic [CW-1:0] r_cnt,       w_cnt;
  logic          w_stop;
  logic          w_finish;
  logic [DW-1:0] w_rd;

  assign w_stop    = (i_req & ~r_i_done) | (d_req & ~r_d_done);
  assign stopCPU   = w_stop;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign err       = r_err;

  always_comb begin
    w_state     = r_state;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_i_rdata   = r_i_rdata;
    w_d_rdata   = r_d_rdata;
    w_err       = r_err;
    w_i_done    = r_i_done;
    w_d_done    = r_d_done;
    w_cnt       = r_cnt;
    w_finish    = 1'b0;
    w_rd        = '0;

    // Step end clears the flags; a completion on the same edge (withdrawn request) still sets its flag.
    if (!w_stop) begin
      w_i_done = 1'b0;
      w_d_done = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (d_req & ~r_d_done) begin
          w_mem_addr  = d_addr;
          w_mem_wdata = d_wdata;
          w_mem_we    = d_we;
          w_mem_req   = 1'b1;
          w_state     = D_ACC;
        end else if (i_req & ~r_i_done) begin
          w_mem_addr  = i_addr;
          w_mem_we    = 1'b0;
          w_mem_req   = 1'b1;
          w_state     = I_ACC;
        end else begin
          w_mem_req   = 1'b0;
        end
      end
      D_ACC, I_ACC: begin
        // mem_ready has priority over the timeout on the same cycle.
        w_finish = mem_ready | (r_cnt == CNT_LAST);
        w_rd     = mem_ready ? mem_rdata : '0;
        if (w_finish) begin
          w_mem_req = 1'b0;
          w_mem_we  = 1'b0;
          w_cnt     = '0;
          w_state   = IDLE;
          if (!mem_ready) w_err = 1'b1;
          if (r_state == D_ACC) begin
            w_d_done = 1'b1;
            if (!r_mem_we) w_d_rdata = w_rd;
          end else begin
            w_i_done  = 1'b1;
            w_i_rdata = w_rd;
          end
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_err       <= 1'b0;
      r_i_done    <= 1'b0;
      r_d_done    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_i_rdata   <= w_i_rdata;
      r_d_rdata   <= w_d_rdata;
      r_err       <= w_err;
      r_i_done    <= w_i_done;
      r_d_done    <= w_d_done;
      r_cnt       <= w_cnt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory responder, transaction-level reference model and directed steps.
// Inputs driven 1 time unit after the rising edge; outputs checked on the falling edge.
module tb_mem_port_arbiter;

  localparam int TO = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        stopCPU;
  logic        err;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stopCPU(stopCPU), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory responder: ready after wait_cfg stalled cycles, logs every access it sees.
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] log_addr[$];
  logic        log_we[$];
  logic [31:0] log_wd[$];
  int          wait_cfg = 0;
  int          rsp_cnt = 0;
  int          req_cycles = 0;
  bit          never_ready = 1'b0;
  bit          stray_ready = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst_n && mem_req) begin
      if (rsp_cnt == 0) begin
        log_addr.push_back(mem_addr);
        log_we.push_back(mem_we);
        log_wd.push_back(mem_wdata);
      end
      req_cycles++;
      if (!never_ready && rsp_cnt == wait_cfg) begin
        mem_ready = 1'b1;
        mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'h0;
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
      end
      rsp_cnt++;
    end else begin
      mem_ready = stray_ready;
      mem_rdata = 32'h5A5A5A5A;
      rsp_cnt   = 0;
    end
  end

  // Reference model: which ports have been served this step, and the one access in flight.
  bit          m_i_srv = 0, m_d_srv = 0, m_err = 0;
  bit          m_busy = 0, m_is_d = 0, m_we = 0;
  logic [31:0] m_addr = '0, m_wd = '0, m_i_rd = '0, m_d_rd = '0, m_rd;
  int          m_elapsed = 0;
  bit          m_stop, m_set_i, m_set_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_i_srv = 0; m_d_srv = 0; m_err = 0; m_busy = 0;
      m_i_rd = '0; m_d_rd = '0;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_err", err, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
    end else begin
      m_stop = (i_req && !m_i_srv) || (d_req && !m_d_srv);
      chk("stopCPU", stopCPU, m_stop);
      chk("mem_req", mem_req, m_busy);
      chk("mem_we", mem_we, m_busy && m_we);
      if (m_busy) begin
        chk("mem_addr", mem_addr, m_addr);
        if (m_we) chk("mem_wdata", mem_wdata, m_wd);
      end
      chk("i_rdata", i_rdata, m_i_rd);
      chk("d_rdata", d_rdata, m_d_rd);
      chk("err", err, m_err);

      m_set_i = 0;
      m_set_d = 0;
      if (m_busy) begin
        m_elapsed++;
        if (mem_ready || m_elapsed >= TO) begin
          m_rd = mem_ready ? mem_rdata : 32'h0;
          if (!mem_ready) m_err = 1;
          if (m_is_d) begin
            m_set_d = 1;
            if (!m_we) m_d_rd = m_rd;
          end else begin
            m_set_i = 1;
            m_i_rd = m_rd;
          end
          m_busy = 0;
        end
      end else if (d_req && !m_d_srv) begin
        m_busy = 1; m_is_d = 1; m_we = d_we; m_addr = d_addr; m_wd = d_wdata; m_elapsed = 0;
      end else if (i_req && !m_i_srv) begin
        m_busy = 1; m_is_d = 0; m_we = 0; m_addr = i_addr; m_elapsed = 0;
      end
      if (!m_stop) begin
        m_i_srv = 0;
        m_d_srv = 0;
      end
      if (m_set_i) m_i_srv = 1;
      if (m_set_d) m_d_srv = 1;
    end
  end

  task automatic run_step(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                          input logic [31:0] da, input logic [31:0] dwd, output int stall);
    bit ended;
    @(posedge clk); #1;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    stall = 0;
    ended = 0;
    for (int k = 0; k < 60 && !ended; k++) begin
      @(negedge clk);
      if (!stopCPU) ended = 1;
      else stall++;
    end
    if (!ended) begin
      n_checks++;
      n_errors++;
      $display("FAIL step_bound: stopCPU still high after %0d cycles, required low", stall);
    end
  endtask

  int stall;
  int n0;
  int rc0;
  bit seen;

  initial begin
    mem_arr[32'h040] = 32'h8C080004;
    mem_arr[32'h044] = 32'h00000013;
    mem_arr[32'h100] = 32'hDEAD0001;
    mem_arr[32'h300] = 32'h0000AAAA;
    mem_arr[32'h000] = 32'h20080001;
    mem_arr[32'h004] = 32'h20090002;
    mem_arr[32'h080] = 32'h11112222;
    mem_arr[32'h084] = 32'h33334444;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stopCPU", stopCPU, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Single zero-wait fetch
    wait_cfg = 0; n0 = log_addr.size(); rc0 = req_cycles;
    run_step(1, 32'h40, 0, 0, 0, 0, stall);
    chk("t1_stall", stall, 2);
    chk("t1_naccess", log_addr.size() - n0, 1);
    chk("t1_addr", log_addr[n0], 32'h40);
    chk("t1_req_cycles", req_cycles - rc0, 1);
    chk("t1_i_rdata", i_rdata, 32'h8C080004);

    // Load and fetch together, two wait cycles each; D must go first
    wait_cfg = 2; n0 = log_addr.size();
    run_step(1, 32'h44, 1, 0, 32'h100, 32'h0, stall);
    chk("t2_stall", stall, 8);
    chk("t2_naccess", log_addr.size() - n0, 2);
    chk("t2_first", log_addr[n0], 32'h100);
    chk("t2_second", log_addr[n0+1], 32'h44);
    chk("t2_d_rdata", d_rdata, 32'hDEAD0001);
    chk("t2_i_rdata", i_rdata, 32'h00000013);
    chk("t2_err", err, 0);

    // Store leaves d_rdata alone
    wait_cfg = 0;
    run_step(0, 32'h0, 1, 0, 32'h300, 32'h0, stall);
    chk("t3_preload", d_rdata, 32'h0000AAAA);
    n0 = log_addr.size();
    run_step(0, 32'h0, 1, 1, 32'h200, 32'h12345678, stall);
    chk("t3_stall", stall, 2);
    chk("t3_naccess", log_addr.size() - n0, 1);
    chk("t3_addr", log_addr[n0], 32'h200);
    chk("t3_we", log_we[n0], 1);
    chk("t3_wdata", log_wd[n0], 32'h12345678);
    chk("t3_mem", mem_arr[32'h200], 32'h12345678);
    chk("t3_d_rdata", d_rdata, 32'h0000AAAA);

    // Back-to-back fetch steps, with stray mem_ready while idle
    stray_ready = 1'b1; n0 = log_addr.size();
    run_step(1, 32'h0, 0, 0, 0, 0, stall);
    chk("t4_stall_a", stall, 2);
    run_step(1, 32'h4, 0, 0, 0, 0, stall);
    chk("t4_stall_b", stall, 2);
    chk("t4_naccess", log_addr.size() - n0, 2);
    chk("t4_addr_a", log_addr[n0], 32'h0);
    chk("t4_addr_b", log_addr[n0+1], 32'h4);
    chk("t4_i_rdata", i_rdata, 32'h20090002);
    stray_ready = 1'b0;

    // Fetch withdrawn mid-access still completes once
    wait_cfg = 2; n0 = log_addr.size();
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h80; d_req = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    i_req = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_naccess", log_addr.size() - n0, 1);
    chk("t5_i_rdata", i_rdata, 32'h11112222);
    run_step(1, 32'h84, 0, 0, 0, 0, stall);
    chk("t5_stall", stall, 4);
    chk("t5_i_rdata2", i_rdata, 32'h33334444);

    // Reset during a data access
    wait_cfg = 1; n0 = log_addr.size();
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (mem_req) seen = 1;
    end
    chk("t6_issued", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_mem_req", mem_req, 0);
    chk("t6_stop_in_rst", stopCPU, 1);
    @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    stall = 0; seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (!stopCPU) seen = 1;
      else stall++;
    end
    chk("t6_step_end", seen, 1);
    chk("t6_stall", stall, 3);
    chk("t6_naccess", log_addr.size() - n0, 2);
    chk("t6_reissue", log_addr[log_addr.size()-1], 32'h100);
    chk("t6_d_rdata", d_rdata, 32'hDEAD0001);

    // Timeout, then err stays set through a good access
    never_ready = 1'b1; rc0 = req_cycles;
    run_step(1, 32'h500, 0, 0, 0, 0, stall);
    chk("t7_stall", stall, 4);
    chk("t7_req_cycles", req_cycles - rc0, TO);
    chk("t7_err", err, 1);
    chk("t7_i_rdata", i_rdata, 32'h0);
    never_ready = 1'b0; wait_cfg = 0;
    run_step(1, 32'h40, 0, 0, 0, 0, stall);
    chk("t7_stall2", stall, 2);
    chk("t7_err_sticky", err, 1);
    chk("t7_i_rdata2", i_rdata, 32'h8C080004);

    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

endmodule
